l1_trig_collector: RTL and testbench

- Downstream of the L1 beamforming trigger. Consumes the per-beam trigger vector (trigger_o, NBEAMS bits) in the ifclk domain.
- Per-beam mask, rising-edge detection and global holdoff.
- Each accepted trigger is timestamped and buffered in a small event FIFO.
- Events are serialized as 16-bit stream words toward the TURF link.

---
 rtl/l1_trig_pkg.sv | 37 +++
 rtl/l1_trig_event_fifo.sv | 80 ++++++++
 rtl/l1_trig_collector.sv | 191 +++++++++++++++++++
 tb/tb_l1_trig_collector.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_trig_pkg.sv
// Shared types for the L1 trigger collector.
//   trig_event_t : one buffered event (16-bit timestamp + 48-bit beam vector)
//   ser_state_t  : serializer states, one per output word plus IDLE
//   event_word() : selects the stream word of an event for a serializer state
package l1_trig_pkg;

  localparam int unsigned WordsPerEvent = 4;
  localparam int unsigned WordWidth     = 16;
  localparam int unsigned BeamBits      = WordWidth * (WordsPerEvent - 1);

  typedef struct packed {
    logic [WordWidth-1:0] ts;
    logic [BeamBits-1:0]  beams;
  } trig_event_t;

  typedef enum logic [$clog2(WordsPerEvent + 1)-1:0] {
    IDLE,
    W0,
    W1,
    W2,
    W3
  } ser_state_t;

  function automatic logic [WordWidth-1:0] event_word(trig_event_t ev, ser_state_t st);
    logic [WordWidth-1:0] word;
    word = '0;
    unique case (st)
      W0:      word = ev.ts;
      W1:      word = ev.beams[15:0];
      W2:      word = ev.beams[31:16];
      W3:      word = ev.beams[47:32];
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/l1_trig_event_fifo.sv
// Synchronous FIFO of trig_event_t with synchronous flush.
// The head entry is presented combinationally on o_rd_data (first-word fall-through);
// i_rd_en pops it. A push into a full FIFO is accepted when a pop happens in the same
// cycle, since the pop frees the slot.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               empty the FIFO (overrides push/pop)
//   i_wr_en, i_wr_data    push
//   i_rd_en, o_rd_data    pop / head entry
//   o_full, o_empty       status
//   o_count               number of stored entries
module l1_trig_event_fifo
  import l1_trig_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_flush,
  input  logic                          i_wr_en,
  input  trig_event_t                   i_wr_data,
  input  logic                          i_rd_en,
  output trig_event_t                   o_rd_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  trig_event_t          r_mem [FIFO_DEPTH];
  logic [AddrW-1:0]     r_wr_ptr;
  logic [AddrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [CntW-1:0]      w_count_d;
  logic                 w_do_wr;
  logic                 w_do_rd;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CntW'(FIFO_DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_do_rd = i_rd_en & ~o_empty;
  assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

  always_comb begin
    w_count_d = r_count;
    if (w_do_wr && !w_do_rd) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_do_wr && w_do_rd) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_d;
    end
  end

  // Storage needs no reset: o_empty gates every use of the contents.
  always_ff @(posedge i_clk) begin
    if (w_do_wr && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/l1_trig_collector.sv
// L1 trigger collector: per-beam mask and rising-edge detect, global holdoff,
// timestamped event FIFO and a 4-word 16-bit stream serializer toward the TURF link.
// Ports:
//   ifclk, ifclk_rst_n   sole clock, asynchronous active-low reset
//   trig_i, mask_i       per-beam trigger levels / beam ignore mask
//   holdoff_i            cycles of holdoff after an accepted event
//   run_start_i          pulse: clears timestamp, FIFO, holdoff, overflow, counters
//   m_tdata/m_tvalid/m_tready/m_tlast   event word stream (ts, beams[15:0], [31:16], [47:32])
//   overflow_o           sticky: an accepted event was lost to a full FIFO
// Optional (macro L1_TRIG_COLLECT_STATS_EN):
//   accepted_count_o     saturating count of events written to the FIFO
//   dropped_count_o      saturating count of edge cycles rejected by holdoff or full FIFO
module l1_trig_collector
  import l1_trig_pkg::*;
#(
  parameter int unsigned NBEAMS     = 46,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_BITS    = 16
) (
  input  logic              ifclk,
  input  logic              ifclk_rst_n,
  input  logic [NBEAMS-1:0] trig_i,
  input  logic [NBEAMS-1:0] mask_i,
  input  logic [7:0]        holdoff_i,
  input  logic              run_start_i,
  output logic [15:0]       m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              overflow_o
`ifdef L1_TRIG_COLLECT_STATS_EN
  ,
  output logic [31:0]       accepted_count_o,
  output logic [31:0]       dropped_count_o
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [NBEAMS-1:0]  r_trig_q;
  logic [TS_BITS-1:0] r_ts;
  logic [7:0]         r_holdoff;
  logic               r_overflow;
  ser_state_t         r_state;
  ser_state_t         w_state_d;

  logic [NBEAMS-1:0]  w_edge;
  logic               w_any_edge;
  logic               w_accept;
  logic               w_hs;
  logic               w_fifo_wr;
  logic               w_fifo_rd;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CntW-1:0]    w_fifo_count;
  logic               w_more;
  trig_event_t        w_wr_event;
  trig_event_t        w_head;

  assign w_edge     = trig_i & ~r_trig_q & ~mask_i;
  assign w_any_edge = |w_edge;
  // run_start_i wins over a coincident edge.
  assign w_accept   = w_any_edge && (r_holdoff == 8'd0) && !run_start_i;
  assign w_hs       = m_tvalid && m_tready;

  // The event being serialized stays at the FIFO head until its last word is taken,
  // so the FIFO pops on the W3 handshake and that pop can make room for a push.
  assign w_fifo_rd  = (r_state == W3) && w_hs && !run_start_i;
  assign w_fifo_wr  = w_accept && (!w_fifo_full || w_fifo_rd);
  // Another event remains after the current head is popped.
  assign w_more     = (w_fifo_count > CntW'(1));

  always_comb begin
    w_wr_event                    = '0;
    w_wr_event.ts                 = r_ts;
    w_wr_event.beams[NBEAMS-1:0]  = w_edge;
  end

  l1_trig_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (ifclk),
    .i_rst_n   (ifclk_rst_n),
    .i_flush   (run_start_i),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (w_wr_event),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Timestamp, edge history, holdoff and sticky overflow.
  always_ff @(posedge ifclk or negedge ifclk_rst_n) begin
    if (!ifclk_rst_n) begin
      r_ts       <= '0;
      r_trig_q   <= '0;
      r_holdoff  <= '0;
      r_overflow <= 1'b0;
    end else if (run_start_i) begin
      r_ts       <= '0;
      r_trig_q   <= trig_i;  // no spurious edges from beams already high
      r_holdoff  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ts     <= r_ts + 1'b1;
      r_trig_q <= trig_i;
      if (w_accept) begin
        r_holdoff <= holdoff_i;
      end else if (r_holdoff != 8'd0) begin
        r_holdoff <= r_holdoff - 1'b1;
      end
      if (w_accept && !w_fifo_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign overflow_o = r_overflow;

  always_ff @(posedge ifclk or negedge ifclk_rst_n) begin
    if (!ifclk_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tdata   = '0;
    unique case (r_state)
      IDLE: begin
        if (!w_fifo_empty) w_state_d = W0;
      end
      W0: begin
        m_tvalid = 1'b1;
        if (m_tready) w_state_d = W1;
      end
      W1: begin
        m_tvalid = 1'b1;
        if (m_tready) w_state_d = W2;
      end
      W2: begin
        m_tvalid = 1'b1;
        if (m_tready) w_state_d = W3;
      end
      W3: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        if (m_tready) w_state_d = w_more ? W0 : IDLE;
      end
      default: w_state_d = IDLE;
    endcase
    if (m_tvalid) begin
      m_tdata = event_word(w_head, r_state);
    end
    // Truncates a partial event; downstream tolerates this at run start.
    if (run_start_i) begin
      w_state_d = IDLE;
    end
  end

`ifdef L1_TRIG_COLLECT_STATS_EN
  logic [31:0] r_acc_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = w_any_edge && !run_start_i && !w_fifo_wr;

  always_ff @(posedge ifclk or negedge ifclk_rst_n) begin
    if (!ifclk_rst_n) begin
      r_acc_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (run_start_i) begin
      r_acc_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fifo_wr && (r_acc_cnt != 32'hFFFF_FFFF)) r_acc_cnt <= r_acc_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign accepted_count_o = r_acc_cnt;
  assign dropped_count_o  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_l1_trig_collector.sv
// Self-checking bench for l1_trig_collector: queue-based event model checked every cycle,
// directed scenarios with literal expectations, and a long randomized phase that also
// carries the timestamp through its 0xFFFF -> 0x0000 wrap.
module tb_l1_trig_collector;

  localparam int NB    = 46;
  localparam int DEPTH = 16;

  logic          ifclk;
  logic          ifclk_rst_n = 1'b0;
  logic [NB-1:0] trig_i      = '0;
  logic [NB-1:0] mask_i      = '0;
  logic [7:0]    holdoff_i   = '0;
  logic          run_start_i = 1'b0;
  logic          m_tready    = 1'b0;
  logic [15:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          overflow_o;
`ifdef L1_TRIG_COLLECT_STATS_EN
  logic [31:0]   accepted_count_o;
  logic [31:0]   dropped_count_o;
`endif

  l1_trig_collector #(
    .NBEAMS     (NB),
    .FIFO_DEPTH (DEPTH),
    .TS_BITS    (16)
  ) dut (
    .ifclk       (ifclk),
    .ifclk_rst_n (ifclk_rst_n),
    .trig_i      (trig_i),
    .mask_i      (mask_i),
    .holdoff_i   (holdoff_i),
    .run_start_i (run_start_i),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .overflow_o  (overflow_o)
`ifdef L1_TRIG_COLLECT_STATS_EN
    ,
    .accepted_count_o (accepted_count_o),
    .dropped_count_o  (dropped_count_o)
`endif
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned ts;
    logic [47:0] beams;
  } ev_t;

  ev_t           m_fifo[$];   // front entry is the one being streamed while m_busy
  bit            m_busy;
  int            m_idx;       // word index within the current event
  int unsigned   m_ts;        // timestamp the DUT will use at the next edge
  logic [NB-1:0] m_prev;
  int            m_hold;
  bit            m_ovf;
  longint        m_acc;
  longint        m_drop;
  int            cyc;

  function automatic logic [15:0] mword(ev_t e, int idx);
    case (idx)
      0:       return e.ts[15:0];
      1:       return e.beams[15:0];
      2:       return e.beams[31:16];
      default: return e.beams[47:32];
    endcase
  endfunction

  initial begin
    m_busy = 0; m_idx = 0; m_ts = 0; m_prev = '0; m_hold = 0; m_ovf = 0;
    m_acc = 0; m_drop = 0; cyc = 0;
    forever begin
      @(posedge ifclk);
      cyc++;
      if (!ifclk_rst_n) begin
        m_fifo.delete(); m_busy = 0; m_idx = 0; m_ts = 0; m_prev = '0;
        m_hold = 0; m_ovf = 0; m_acc = 0; m_drop = 0;
      end else if (run_start_i) begin
        m_fifo.delete(); m_busy = 0; m_idx = 0; m_ts = 0; m_prev = trig_i;
        m_hold = 0; m_ovf = 0; m_acc = 0; m_drop = 0;
      end else begin
        logic [NB-1:0] e;
        bit hs, pop, acc, wr;
        ev_t ev;
        e   = trig_i & ~m_prev & ~mask_i;
        hs  = m_busy && m_tready;
        pop = m_busy && (m_idx == 3) && hs;
        acc = (e != '0) && (m_hold == 0);
        wr  = acc && ((m_fifo.size() < DEPTH) || pop);
        if (!m_busy) begin
          if (m_fifo.size() > 0) begin m_busy = 1; m_idx = 0; end
        end else if (hs) begin
          if (m_idx == 3) begin
            void'(m_fifo.pop_front());
            if (m_fifo.size() > 0) m_idx = 0;
            else m_busy = 0;
          end else begin
            m_idx++;
          end
        end
        if (wr) begin
          ev.ts = m_ts;
          ev.beams = '0;
          ev.beams[NB-1:0] = e;
          m_fifo.push_back(ev);
          m_acc++;
        end
        if (acc && !wr) m_ovf = 1;
        if ((e != '0) && !wr) m_drop++;
        if (acc) m_hold = holdoff_i;
        else if (m_hold > 0) m_hold--;
        m_ts   = (m_ts + 1) & 32'hFFFF;
        m_prev = trig_i;
      end
    end
  end

  // ---------------- compare process + handshake log ----------------
  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } beat_t;
  beat_t log_q[$];

  initial begin
    forever begin
      @(negedge ifclk);
      if (ifclk_rst_n) begin
        check("tvalid", m_tvalid, m_busy);
        if (m_busy) begin
          check("tdata", m_tdata, mword(m_fifo[0], m_idx));
          check("tlast", m_tlast, m_idx == 3);
        end
        check("overflow", overflow_o, m_ovf);
`ifdef L1_TRIG_COLLECT_STATS_EN
        check("accepted_count", accepted_count_o, m_acc);
        check("dropped_count", dropped_count_o, m_drop);
`endif
        if (m_tvalid && m_tready) log_q.push_back('{data: m_tdata, last: m_tlast, cyc: cyc});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge ifclk);
      #2;
    end
  endtask

  task automatic pulse_run_start();
    run_start_i = 1'b1;
    tick();
    run_start_i = 1'b0;
  endtask

  task automatic wait_ts(int unsigned t);
    int guard = 0;
    while (m_ts != t && guard < 70000) begin
      tick();
      guard++;
    end
    if (guard >= 70000) begin
      checks++;
      errors++;
      $display("FAIL wait_ts: timestamp %0h never reached, at %0h", t, m_ts);
    end
  endtask

  task automatic fill_onehot(int base);
    for (int i = 0; i < 20; i++) begin
      trig_i = '0;
      trig_i[base + i] = 1'b1;
      tick();
    end
    trig_i = '0;
    tick(2);
  endtask

  logic [15:0] exp3 [12];
  logic [15:0] expw [8];

  initial begin
    #1;
    check("reset_tvalid", m_tvalid, 0);
    check("reset_tdata", m_tdata, 0);
    check("reset_tlast", m_tlast, 0);
    check("reset_overflow", overflow_o, 0);
    tick(3);
    ifclk_rst_n = 1'b1;
    tick(2);

    // Single event; a held-high beam must not retrigger.
    m_tready = 1'b1;
    pulse_run_start();
    log_q.delete();
    wait_ts(16'h0010);
    trig_i[5] = 1'b1;
    tick(30);
    check("t1_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t1_w0", log_q[0].data, 16'h0010);
      check("t1_w1", log_q[1].data, 16'h0020);
      check("t1_w2", log_q[2].data, 16'h0000);
      check("t1_w3", log_q[3].data, 16'h0000);
      check("t1_last3", log_q[3].last, 1);
      check("t1_last0", log_q[0].last, 0);
    end

    // Mask and holdoff.
    trig_i = '0;
    mask_i[3] = 1'b1;
    holdoff_i = 8'd10;
    tick(3);
    pulse_run_start();
    log_q.delete();
    trig_i[3] = 1'b1;
    tick(2);
    trig_i[7] = 1'b1;
    tick(5);
    trig_i[8] = 1'b1;
    tick(6);
    trig_i[9] = 1'b1;
    tick(30);
    check("t2_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      check("t2_beam7", log_q[1].data, 16'h0080);
      check("t2_beam9", log_q[5].data, 16'h0200);
      check("t2_ts_delta", 16'(log_q[4].data - log_q[0].data), 11);
    end

    // Backpressure with three queued events.
    trig_i = '0;
    mask_i = '0;
    holdoff_i = 8'd0;
    m_tready = 1'b0;
    tick(2);
    pulse_run_start();
    log_q.delete();
    wait_ts(5);
    trig_i[1] = 1'b1;
    tick();
    trig_i[2] = 1'b1;
    tick();
    trig_i[3] = 1'b1;
    tick(50);
    check("t3_stall_valid", m_tvalid, 1);
    check("t3_stall_data", m_tdata, 16'h0005);
    check("t3_stall_nobeat", log_q.size(), 0);
    m_tready = 1'b1;
    tick(20);
    exp3 = '{16'h5, 16'h2, 16'h0, 16'h0, 16'h6, 16'h4, 16'h0, 16'h0,
             16'h7, 16'h8, 16'h0, 16'h0};
    check("t3_count", log_q.size(), 12);
    if (log_q.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check("t3_word", log_q[i].data, exp3[i]);
        check("t3_last", log_q[i].last, (i % 4) == 3);
        check("t3_contiguous", log_q[i].cyc, log_q[0].cyc + i);
      end
    end

    // Overflow: 20 edge cycles into a 16-deep FIFO with the stream stalled.
    trig_i = '0;
    m_tready = 1'b0;
    tick(2);
    pulse_run_start();
    log_q.delete();
    fill_onehot(0);
    check("t4_overflow", overflow_o, 1);
`ifdef L1_TRIG_COLLECT_STATS_EN
    check("t4_accepted", accepted_count_o, 16);
    check("t4_dropped", dropped_count_o, 4);
`endif
    m_tready = 1'b1;
    tick(80);
    check("t4_count", log_q.size(), 64);
    if (log_q.size() == 64) begin
      for (int k = 0; k < 16; k++) begin
        check("t4_ts", log_q[4 * k].data, k);
        check("t4_beam", log_q[4 * k + 1].data, 64'(1) << k);
      end
    end

    // run_start during W2.
    m_tready = 1'b0;
    tick(2);
    log_q.delete();
    fill_onehot(20);
    check("t6_overflow_set", overflow_o, 1);
    m_tready = 1'b1;
    tick(2);
    m_tready = 1'b0;
    check("t6_w2_data", m_tdata, 16'h0010);
    check("t6_w2_last", m_tlast, 0);
    pulse_run_start();
    check("t6_valid_low", m_tvalid, 0);
    check("t6_overflow_clr", overflow_o, 0);
    m_tready = 1'b1;
    tick(20);
    check("t6_flushed", log_q.size(), 2);

    // Asynchronous reset mid-stream.
    m_tready = 1'b0;
    fill_onehot(0);
    check("t7_pre_valid", m_tvalid, 1);
    check("t7_pre_overflow", overflow_o, 1);
    ifclk_rst_n = 1'b0;
    #1;
    check("t7_rst_valid", m_tvalid, 0);
    check("t7_rst_data", m_tdata, 0);
    check("t7_rst_last", m_tlast, 0);
    check("t7_rst_overflow", overflow_o, 0);
    tick();
    ifclk_rst_n = 1'b1;
    tick(2);

    // Randomized phase, running the timestamp up to its wrap.
    pulse_run_start();
    begin
      int guard = 0;
      int idx;
      while (m_ts != 16'hFF00 && guard < 70000) begin
        if ($urandom_range(3) == 0) begin
          idx = $urandom_range(NB - 1);
          trig_i[idx] = ~trig_i[idx];
        end
        if ($urandom_range(15) == 0) trig_i = trig_i ^ NB'({$urandom, $urandom});
        if ($urandom_range(499) == 0) begin
          idx = $urandom_range(NB - 1);
          mask_i[idx] = ~mask_i[idx];
        end
        if ($urandom_range(199) == 0) holdoff_i = 8'($urandom_range(15));
        if (m_ts[10]) m_tready = ($urandom_range(9) < 3);
        else m_tready = ($urandom_range(9) < 9);
        tick();
        guard++;
      end
      if (guard >= 70000) begin
        checks++;
        errors++;
        $display("FAIL random_phase: timestamp stuck at %0h", m_ts);
      end
    end

    // Timestamp wrap and top-beam packing.
    trig_i = '0;
    mask_i = '0;
    holdoff_i = 8'd0;
    m_tready = 1'b1;
    wait_ts(16'hFFF0);
    log_q.delete();
    wait_ts(16'hFFFF);
    trig_i[0] = 1'b1;
    trig_i[45] = 1'b1;
    tick();
    trig_i[10] = 1'b1;
    tick(20);
    expw = '{16'hFFFF, 16'h0001, 16'h0000, 16'h2000, 16'h0000, 16'h0400, 16'h0000, 16'h0000};
    check("t5_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t5_word", log_q[i].data, expw[i]);
        check("t5_last", log_q[i].last, (i % 4) == 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
